// File: rtl/comb_agree_if.sv
// Sample/result bundle between the comb implementations' stimulus source and the agreement
// checker.
interface comb_agree_if #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned N_IMPL = 4,
    parameter int unsigned CNT_W  = 8
);
    logic              clr;
    logic              valid;
    logic [IN_W-1:0]   in_vec;
    logic [N_IMPL-1:0] y;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [N_IMPL-1:0] bad_impl;
    logic [IN_W-1:0]   first_vec;
    logic [N_IMPL-1:0] first_y;
    logic [IN_W:0]     cov_cnt;

    modport master (
        output clr, valid, in_vec, y,
        input  busy, done, err, mismatch_cnt, bad_impl, first_vec, first_y, cov_cnt
    );

    modport slave (
        input  clr, valid, in_vec, y,
        output busy, done, err, mismatch_cnt, bad_impl, first_vec, first_y, cov_cnt
    );
endinterface

// File: rtl/comb_agree_checker.sv
// Checks that all comb implementations agree with y[0] on every sampled vector and tracks
// input-space coverage until every vector has been seen.
module comb_agree_checker #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned N_IMPL = 4,
    parameter int unsigned CNT_W  = 8
) (
    input logic         clk,
    input logic         rst,
    comb_agree_if.slave bus
);
    localparam int unsigned NumVec = 2 ** IN_W;
    localparam logic [IN_W:0] CovFull = (IN_W + 1)'(NumVec);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  mismatch_cnt_q;
    logic [N_IMPL-1:0] bad_impl_q;
    logic [IN_W-1:0]   first_vec_q;
    logic [N_IMPL-1:0] first_y_q;
    logic [IN_W:0]     cov_cnt_q;
    logic [NumVec-1:0] seen_q;

    logic [N_IMPL-1:0] mm;
    logic              any_mm;
    logic              new_vec;
    logic [IN_W:0]     cov_next;

    // Case inequality so an X/Z on any implementation output counts as a disagreement.
    always_comb begin
        mm = '0;
        for (int i = 1; i < N_IMPL; i++) begin
            mm[i] = (bus.y[i] !== bus.y[0]);
        end
        any_mm   = |mm;
        new_vec  = ~seen_q[bus.in_vec];
        cov_next = cov_cnt_q + {{IN_W{1'b0}}, new_vec};
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_q        <= StIdle;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            mismatch_cnt_q <= '0;
            bad_impl_q     <= '0;
            first_vec_q    <= '0;
            first_y_q      <= '0;
            cov_cnt_q      <= '0;
            seen_q         <= '0;
        end else begin
            case (state_q)
                StIdle, StRun: begin
                    if (bus.valid) begin
                        if (any_mm) begin
                            err_q      <= 1'b1;
                            bad_impl_q <= bad_impl_q | mm;
                            if (mismatch_cnt_q != '1) begin
                                mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
                            end
                            if (!err_q) begin
                                first_vec_q <= bus.in_vec;
                                first_y_q   <= bus.y;
                            end
                        end
                        if (new_vec) begin
                            seen_q[bus.in_vec] <= 1'b1;
                            cov_cnt_q          <= cov_next;
                        end
                        if (cov_next == CovFull) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                StDone: ;
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.mismatch_cnt = mismatch_cnt_q;
    assign bus.bad_impl     = bad_impl_q;
    assign bus.first_vec    = first_vec_q;
    assign bus.first_y      = first_y_q;
    assign bus.cov_cnt      = cov_cnt_q;
endmodule

// File: tb/tb_comb_agree_checker.sv
// Scoreboard bench for comb_agree_checker: the driver pushes expected outputs per cycle and a
// monitor pops and compares them one cycle later; directed end-of-scenario checks use constants.
module tb_comb_agree_checker;
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] mcnt;
        logic [3:0] bad;
        logic [3:0] fvec;
        logic [3:0] fy;
        logic [4:0] cov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];

    // Bench-side reference state.
    int         m_state = 0;  // 0 idle, 1 run, 2 done
    bit [15:0]  m_seen  = '0;
    exp_t       m       = '0;

    comb_agree_if #(.IN_W(4), .N_IMPL(4), .CNT_W(8)) bus ();

    comb_agree_checker #(.IN_W(4), .N_IMPL(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t dut_now();
        exp_t a;
        a.busy = bus.busy;
        a.done = bus.done;
        a.err  = bus.err;
        a.mcnt = bus.mismatch_cnt;
        a.bad  = bus.bad_impl;
        a.fvec = bus.first_vec;
        a.fy   = bus.first_y;
        a.cov  = bus.cov_cnt;
        return a;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit v, input logic [3:0] vec,
                              input logic [3:0] yy);
        logic [3:0] mmv;
        if (r || c) begin
            m_state = 0;
            m_seen  = '0;
            m       = '0;
        end else if (v && m_state != 2) begin
            mmv = yy ^ (yy[0] ? 4'hF : 4'h0);
            if (mmv != 4'h0) begin
                if (!m.err) begin
                    m.fvec = vec;
                    m.fy   = yy;
                end
                m.err = 1'b1;
                m.bad = m.bad | mmv;
                if (m.mcnt != 8'hFF) m.mcnt = m.mcnt + 8'd1;
            end
            if (!m_seen[vec]) begin
                m_seen[vec] = 1'b1;
                m.cov       = m.cov + 5'd1;
            end
            m_state = (m.cov == 5'd16) ? 2 : 1;
        end
        m.busy = (m_state == 1);
        m.done = (m_state == 2);
    endtask

    task automatic drive(input bit r, input bit c, input bit v, input logic [3:0] vec,
                         input logic [3:0] yy);
        @(negedge clk);
        rst        = r;
        bus.clr    = c;
        bus.valid  = v;
        bus.in_vec = vec;
        bus.y      = yy;
        model_step(r, c, v, vec, yy);
        q.push_back(m);
    endtask

    // Directed check against hand-computed constants, then leave the inputs idle for a cycle.
    task automatic hand(input string name, input exp_t e);
        exp_t a;
        @(negedge clk);
        a = dut_now();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got busy=%b done=%b err=%b mcnt=%0d bad=%b fvec=%0d fy=%b cov=%0d, want busy=%b done=%b err=%b mcnt=%0d bad=%b fvec=%0d fy=%b cov=%0d",
                     name, a.busy, a.done, a.err, a.mcnt, a.bad, a.fvec, a.fy, a.cov,
                     e.busy, e.done, e.err, e.mcnt, e.bad, e.fvec, e.fy, e.cov);
        end
        rst       = 1'b0;
        bus.clr   = 1'b0;
        bus.valid = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        q.push_back(m);
    endtask

    function automatic exp_t mk(input logic b, input logic d, input logic e, input logic [7:0] mc,
                                input logic [3:0] bi, input logic [3:0] fv, input logic [3:0] fy,
                                input logic [4:0] cv);
        exp_t x;
        x.busy = b; x.done = d; x.err = e; x.mcnt = mc;
        x.bad = bi; x.fvec = fv; x.fy = fy; x.cov = cv;
        return x;
    endfunction

    // Monitor: outputs registered at a posedge must match what the driver pushed before it.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = dut_now();
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard@%0t: got %h want %h", $time, a, e);
                end
            end
        end
    end

    initial begin
        bus.clr    = 1'b0;
        bus.valid  = 1'b0;
        bus.in_vec = 4'h0;
        bus.y      = 4'h0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        hand("reset", mk(0, 0, 0, 8'd0, 4'b0, 4'd0, 4'b0, 5'd0));

        // 1: full clean sweep
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'(i), (i % 2 == 1) ? 4'hF : 4'h0);
            if (i == 14) hand("sweep_15", mk(1, 0, 0, 8'd0, 4'b0, 4'd0, 4'b0, 5'd15));
        end
        hand("sweep_done", mk(0, 1, 0, 8'd0, 4'b0, 4'd0, 4'b0, 5'd16));

        // 2: sweep with one bad implementation at vector 9
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'(i), (i == 9) ? 4'b0100 : 4'h0);
        end
        hand("sweep_mm9", mk(0, 1, 1, 8'd1, 4'b0100, 4'd9, 4'b0100, 5'd16));

        // 6: DONE ignores further samples
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'b1010);
        drive(1'b0, 1'b0, 1'b1, 4'd4, 4'b0110);
        hand("done_frozen", mk(0, 1, 1, 8'd1, 4'b0100, 4'd9, 4'b0100, 5'd16));

        // 3: repeated vectors do not add coverage
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'h0);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'hF);
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'h0);
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'hF);
        hand("repeat_cov", mk(1, 0, 0, 8'd0, 4'b0, 4'd0, 4'b0, 5'd2));

        // 4: mismatch counter saturates
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b1, 4'd5, 4'b0010);
        hand("saturate", mk(1, 0, 1, 8'd255, 4'b0010, 4'd5, 4'b0010, 5'd1));

        // 5: clr with valid mid-run drops the sample and clears everything
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'(i), (i == 2) ? 4'b0001 : 4'h0);
        end
        drive(1'b0, 1'b0, 1'b1, 4'd7, 4'b1000);
        hand("pre_clr", mk(1, 0, 1, 8'd2, 4'b1110, 4'd2, 4'b0001, 5'd8));
        drive(1'b0, 1'b1, 1'b1, 4'd9, 4'b0110);
        hand("clr_wins", mk(0, 0, 0, 8'd0, 4'b0, 4'd0, 4'b0, 5'd0));
        // seen-mask must also be cleared: vector 0 counts again
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'hF);
        hand("after_clr", mk(1, 0, 0, 8'd0, 4'b0, 4'd0, 4'b0, 5'd1));

        // valid low: no state change
        drive(1'b0, 1'b0, 1'b0, 4'd6, 4'b0110);
        hand("valid_low", mk(1, 0, 0, 8'd0, 4'b0, 4'd0, 4'b0, 5'd1));

        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
